// File: rtl/csa_acc_pkg.sv
// Shared types and helpers for the carry-save stream accumulator.
// Holds the FSM state encoding, the fixed datapath width and the majority function.
package csa_acc_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    // Bitwise majority: the carry output of a row of full adders.
    function automatic logic [WIDTH-1:0] maj3(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/csa_stream_accumulator_csa.sv
// 32-bit resolve adder: S = X + Y + Cin with carry-out and signed overflow.
// Purely combinational; the accumulator registers its outputs.
module csa_stream_accumulator_csa
    import csa_acc_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             of
);

    logic [WIDTH:0] total_s;

    // Full-width add; the extra bit becomes the carry-out.
    always_comb begin
        total_s = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        s       = total_s[WIDTH-1:0];
        cout    = total_s[WIDTH];
        // Signed overflow: like-signed operands give an opposite-signed result.
        of      = (x[WIDTH-1] == y[WIDTH-1]) && (total_s[WIDTH-1] != x[WIDTH-1]);
    end

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand accumulator: keeps the running total in sum/carry form
// (one 3:2 compression per beat) and resolves it with a single carry-propagate add.
module csa_stream_accumulator
    import csa_acc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_of,
    output logic             out_wrap,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] carry_q, carry_d;
    logic             cin_q, cin_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic             res_of_q, res_of_d;
    logic             res_wrap_q, res_wrap_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

    logic             accept_s;
    logic [WIDTH-1:0] carry_sh_s;
    logic [WIDTH-1:0] add_s_s;
    logic             add_cout_s;
    logic             add_of_s;

    assign carry_sh_s = {carry_q[WIDTH-2:0], 1'b0};

    csa_stream_accumulator_csa u_csa (
        .x    (sum_q),
        .y    (carry_sh_s),
        .cin  (cin_q),
        .s    (add_s_s),
        .cout (add_cout_s),
        .of   (add_of_s)
    );

    // Handshake flags decoded straight from the state register.
    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == ACCUM);
        out_valid = (state_q == HOLD);
        accept_s  = in_valid & in_ready;
    end

    // Next-state and datapath update for the accumulate/resolve/hold sequence.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        cin_d      = cin_q;
        wrap_d     = wrap_q;
        cnt_d      = cnt_q;
        res_sum_d  = res_sum_q;
        res_cout_d = res_cout_q;
        res_of_d   = res_of_q;
        res_wrap_d = res_wrap_q;
        res_cnt_d  = res_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    sum_d   = in_data;
                    carry_d = {WIDTH{1'b0}};
                    cin_d   = in_cin;
                    wrap_d  = 1'b0;
                    cnt_d   = CNT_ONE;
                    state_d = in_last ? RESOLVE : ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    sum_d   = sum_q ^ carry_sh_s ^ in_data;
                    carry_d = maj3(sum_q, carry_sh_s, in_data);
                    // carry_q[31] falls off the top when shifted into weight 2^32.
                    wrap_d  = wrap_q | carry_q[WIDTH-1];
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                    state_d = in_last ? RESOLVE : ACCUM;
                end else begin
                    state_d = ACCUM;
                end
            end
            RESOLVE: begin
                res_sum_d  = add_s_s;
                res_cout_d = add_cout_s;
                res_of_d   = add_of_s;
                // Any weight-2^32 bit lost, including the final carry-out, marks a wrap.
                res_wrap_d = wrap_q | carry_q[WIDTH-1] | add_cout_s;
                res_cnt_d  = cnt_q;
                state_d    = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any partial packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sum_q      <= {WIDTH{1'b0}};
            carry_q    <= {WIDTH{1'b0}};
            cin_q      <= 1'b0;
            wrap_q     <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            res_sum_q  <= {WIDTH{1'b0}};
            res_cout_q <= 1'b0;
            res_of_q   <= 1'b0;
            res_wrap_q <= 1'b0;
            res_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            cin_q      <= cin_d;
            wrap_q     <= wrap_d;
            cnt_q      <= cnt_d;
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
            res_of_q   <= res_of_d;
            res_wrap_q <= res_wrap_d;
            res_cnt_q  <= res_cnt_d;
        end
    end

    assign out_sum   = res_sum_q;
    assign out_cout  = res_cout_q;
    assign out_of    = res_of_q;
    assign out_wrap  = res_wrap_q;
    assign out_count = res_cnt_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Self-checking bench for csa_stream_accumulator: directed vector table,
// hand-written corner sequences and random packets against an arithmetic model.
module tb_csa_stream_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_of;
    logic        out_wrap;
    logic [7:0]  out_count;

    int n_cmp;
    int n_err;

    logic [31:0] pkt_q[$];

    typedef struct {
        int              n;
        logic [3:0][31:0] d;
        logic            cin;
        logic [31:0]     e_sum;
        logic            e_cout;
        logic            e_of;
        logic            e_wrap;
        logic [7:0]      e_cnt;
    } vec_t;

    vec_t vecs[5];

    csa_stream_accumulator #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_of    (out_of),
        .out_wrap  (out_wrap),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drives pkt_q as beats; in_cin only meaningful on the first beat.
    task automatic drive_packet(input logic cin_v, input logic mark_last);
        int k;
        for (int i = 0; i < pkt_q.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = pkt_q[i];
            in_last  = mark_last && (i == pkt_q.size() - 1);
            in_cin   = (i == 0) ? cin_v : 1'($urandom_range(1, 0));
            k = 0;
            while (!in_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (k >= 50) check("ready_timeout", 32'd1, 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
    endtask

    // Waits for out_valid; called at the first negedge after the last accept.
    task automatic wait_result();
        int k;
        k = 1;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'd2);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("rel_valid", {31'd0, out_valid}, 32'd0);
        check("rel_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        longint unsigned total;
        int              nb;
        logic            cin_v;
        logic [31:0]     hold_sum;
        logic [7:0]      hold_cnt;
        logic            hold_flags [3];
        bit              stable;

        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{1, {32'd0, 32'd0, 32'd0, 32'd5}, 1'b1, 32'd6, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[1] = '{3, {32'd0, 32'd1, 32'd1, 32'hFFFF_FFFF}, 1'b0, 32'd1, 1'b1, 1'b0, 1'b1, 8'd3};
        vecs[2] = '{2, {32'd0, 32'd0, 32'd1, 32'h7FFF_FFFF}, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 8'd2};
        vecs[3] = '{3, {32'd0, 32'd30, 32'd20, 32'd10}, 1'b1, 32'd61, 1'b0, 1'b0, 1'b0, 8'd3};
        vecs[4] = '{2, {32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 8'd2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_sum", out_sum, 32'd0);
        check("rst_count", {24'd0, out_count}, 32'd0);
        check("rst_flags", {29'd0, out_cout, out_of, out_wrap}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        for (int v = 0; v < 5; v++) begin
            pkt_q.delete();
            for (int i = 0; i < vecs[v].n; i++) pkt_q.push_back(vecs[v].d[i]);
            drive_packet(vecs[v].cin, 1'b1);
            wait_result();
            check("vec_sum", out_sum, vecs[v].e_sum);
            check("vec_cout", {31'd0, out_cout}, {31'd0, vecs[v].e_cout});
            check("vec_of", {31'd0, out_of}, {31'd0, vecs[v].e_of});
            check("vec_wrap", {31'd0, out_wrap}, {31'd0, vecs[v].e_wrap});
            check("vec_count", {24'd0, out_count}, {24'd0, vecs[v].e_cnt});
            release_out();
        end

        // Backpressure: result held, pending beat not consumed until after handshake.
        pkt_q.delete();
        pkt_q.push_back(32'd100);
        pkt_q.push_back(32'd23);
        drive_packet(1'b0, 1'b1);
        wait_result();
        hold_sum = out_sum;
        hold_cnt = out_count;
        hold_flags[0] = out_cout;
        hold_flags[1] = out_of;
        hold_flags[2] = out_wrap;
        check("bp_sum", hold_sum, 32'd123);
        in_valid = 1'b1;
        in_data  = 32'd7;
        in_last  = 1'b1;
        in_cin   = 1'b0;
        stable   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!out_valid || in_ready || out_sum !== hold_sum || out_count !== hold_cnt ||
                out_cout !== hold_flags[0] || out_of !== hold_flags[1] || out_wrap !== hold_flags[2])
                stable = 1'b0;
        end
        check("bp_stable", {31'd0, stable}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_rel_valid", {31'd0, out_valid}, 32'd0);
        check("bp_rel_ready", {31'd0, in_ready}, 32'd1);
        check("bp_keep_sum", out_sum, 32'd123);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_result();
        check("bp_next_sum", out_sum, 32'd7);
        check("bp_next_count", {24'd0, out_count}, 32'd1);

        // Reset while holding a result.
        #1 rst_n = 1'b0;
        #1;
        check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        check("rst_hold_ready", {31'd0, in_ready}, 32'd1);
        check("rst_hold_sum", out_sum, 32'd0);
        #1 rst_n = 1'b1;

        // Reset mid-packet: 2 of 4 beats, then a fresh single-beat packet.
        pkt_q.delete();
        pkt_q.push_back(32'd1);
        pkt_q.push_back(32'd1);
        drive_packet(1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        #1 rst_n = 1'b1;
        pkt_q.delete();
        pkt_q.push_back(32'd3);
        drive_packet(1'b0, 1'b1);
        wait_result();
        check("rst_mid_sum", out_sum, 32'd3);
        check("rst_mid_count", {24'd0, out_count}, 32'd1);
        release_out();

        // 300 ones: counter saturates, sum does not.
        pkt_q.delete();
        for (int i = 0; i < 300; i++) pkt_q.push_back(32'd1);
        drive_packet(1'b0, 1'b1);
        wait_result();
        check("long_sum", out_sum, 32'd300);
        check("long_count", {24'd0, out_count}, 32'd255);
        check("long_wrap", {31'd0, out_wrap}, 32'd0);
        release_out();

        // Random packets against the mathematical total.
        for (int p = 0; p < 40; p++) begin
            nb    = $urandom_range(12, 1);
            cin_v = 1'($urandom_range(1, 0));
            pkt_q.delete();
            total = 64'(cin_v);
            for (int i = 0; i < nb; i++) begin
                logic [31:0] d;
                case ($urandom_range(3, 0))
                    0:       d = $urandom_range(255, 0);
                    1:       d = 32'hFFFF_FFFF - 32'($urandom_range(255, 0));
                    default: d = $urandom;
                endcase
                pkt_q.push_back(d);
                total += 64'(d);
            end
            drive_packet(cin_v, 1'b1);
            wait_result();
            check("rnd_sum", out_sum, total[31:0]);
            check("rnd_wrap", {31'd0, out_wrap}, {31'd0, (total >= 64'h1_0000_0000)});
            check("rnd_count", {24'd0, out_count}, 32'(nb));
            repeat ($urandom_range(3, 0)) @(negedge clk);
            release_out();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
